div_iter: RTL and testbench
===========================

// Module: div_iter
// PURPOSE
//  Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
//  - Computes quotient and remainder, which feed the HI/LO write path.
//  - Drives stall_div, which becomes stall_divE at the hazard unit and holds
//    F/D/E while a division is in flight.
//  - One division at a time; fixed latency; cancellable.
// PARAMETERS
//  WIDTH  32  operand width; iteration count equals WIDTH
// PORTS
//  clk        in   1        clock; everything on rising edge
//  resetn     in   1        asynchronous, active-low reset
//  start      in   1        divide instruction present in E (held while stalled)
//  signed_div in   1        1=DIV (two's complement), 0=DIVU
//  annul      in   1        cancel in-flight op (flush/exception)
//  opa        in   WIDTH    dividend (rs)
//  opb        in   WIDTH    divisor (rt)
//  stall_div  out  1        request pipeline stall (-> stall_divE)
//  ready      out  1        result valid this cycle (one-cycle pulse)
//  result     out  2*WIDTH  {remainder(HI), quotient(LO)}
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, result=0, ready=0, stall_div=0.
//  States: IDLE -> BUSY -> DONE -> IDLE.
//  IDLE:
//   - On start & ~annul: latch |opa|, |opb| (abs only if signed_div), the
//     quotient sign (sa^sb), the remainder sign (sa) and a div-by-zero flag.
//   - Clear the partial remainder and set counter=WIDTH; next state BUSY.
//  BUSY (WIDTH cycles):
//   - Each cycle: shift {rem,quo} left 1; trial = rem - divisor (WIDTH+1 bits).
//   - If trial is non-negative: rem=trial, quo[0]=1; otherwise quo[0]=0.
//   - Decrement counter. At counter==1 the next state is DONE.
//  DONE (1 cycle):
//   - result = sign-fixed {rem,quo}; ready=1; next state IDLE unconditionally.
//   - If start is still high in the following IDLE cycle, that is a new divide.
//  stall_div = (state==IDLE & start & ~annul) | (state==BUSY & ~annul).
//   - It is combinational and low in DONE, so E advances in the DONE cycle.
//  Latency:
//   - start seen in IDLE at cycle 0; ready at cycle WIDTH+1 (33).
//   - stall_div is high for cycles 0..WIDTH.
//  result is registered and holds its value after DONE until the next DONE.
//  ready is low in all other states.
//  Sign fix-up (signed_div=1):
//   - Quotient is negated if qsign; remainder is negated if rsign.
//   - Remainder sign always follows the dividend.
//   - Overflow 0x80000000 / -1 yields quo=0x80000000, rem=0 (natural wrap,
//     no trap).
//  Divide by zero: same latency; result = {rem=opa as latched, quo=all ones},
//   regardless of signedness.
//  annul:
//   - Any state: next state IDLE, counter cleared, ready forced 0 the same
//     cycle, result unchanged.
//   - annul has priority over start.
//  resetn low mid-operation: immediate return to the reset values; no partial
//   result is ever presented.
//  Width rules:
//   - Partial remainder is WIDTH+1 bits for the trial subtract.
//   - Counter width is $clog2(WIDTH)+1.
// STRUCTURE
//  Shared defines package: state encodings DIV_IDLE=2'b00, DIV_BUSY=2'b01,
//   DIV_DONE=2'b10 and the WIDTH default.
//  No sub-module: abs and negate are local functions; the datapath is one
//   shift/subtract.
// TESTING
//  1. DIVU 100/7: start held -> stall_div high 33 cycles; ready at cycle 33,
//     result={32'd2, 32'd14}.
//  2. DIV -7/2 -> quo=0xFFFFFFFD (-3), rem=0xFFFFFFFF (-1).
//     DIV 7/-2 -> quo=-3, rem=1.
//  3. DIV 0x80000000/0xFFFFFFFF -> quo=0x80000000, rem=0.
//     DIVU 0xFFFFFFFF/1 -> quo=0xFFFFFFFF, rem=0.
//  4. DIVU 5/0 -> latency 33, quo=0xFFFFFFFF, rem=5.
//     No X on outputs.
//  5. annul at cycle 10 of BUSY -> stall_div=0 that cycle, IDLE next, no ready.
//     Following start with 9/3 -> quo=3, rem=0.
//  6. Back-to-back: start held across DONE with new operands 20/6 -> second
//     op starts the cycle after DONE, result={2,3}.
//     resetn pulse mid-BUSY -> all outputs 0 immediately.

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared encodings and defaults for the iterative divider.
package div_iter_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_iter_if.sv
// Divider request/result bundle between the EX stage (master) and the divider (slave).
interface div_iter_if import div_iter_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
);

  logic               start;
  logic               signed_div;
  logic               annul;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic               stall_div;
  logic               ready;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, signed_div, annul, opa, opb,
    input  stall_div, ready, result
  );

  modport slave (
    input  start, signed_div, annul, opa, opb,
    output stall_div, ready, result
  );

endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring DIV/DIVU: result valid WIDTH+1 cycles after start; stall_div
// holds the pipeline from the start cycle through the last iteration, annul aborts.
module div_iter import div_iter_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic      clk,
  input  logic      resetn,
  div_iter_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  div_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               qsign_q, qsign_d;
  logic               rsign_q, rsign_d;
  logic               dz_q, dz_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  logic               sa, sb;
  logic [WIDTH:0]     shl_rem, trial;
  logic [WIDTH-1:0]   rem_it, quo_it;
  logic               stall, rdy;

  assign sa = bus.signed_div & bus.opa[WIDTH-1];
  assign sb = bus.signed_div & bus.opb[WIDTH-1];

  // One restoring step: a borrow out of the trial subtract means "keep the old remainder".
  assign shl_rem = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shl_rem - {1'b0, dvs_q};
  assign rem_it  = trial[WIDTH] ? shl_rem[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_it  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    dz_d    = dz_q;
    res_d   = res_q;
    stall   = 1'b0;
    rdy     = 1'b0;

    case (state_q)
      DIV_IDLE: begin
        if (bus.start && !bus.annul) begin
          stall   = 1'b1;
          quo_d   = cond_neg(bus.opa, sa);
          dvs_d   = cond_neg(bus.opb, sb);
          rem_d   = '0;
          qsign_d = sa ^ sb;
          rsign_d = sa;
          dz_d    = (bus.opb == '0);
          cnt_d   = CW'(WIDTH);
          state_d = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        stall = !bus.annul;
        rem_d = rem_it;
        quo_d = quo_it;
        cnt_d = cnt_q - CW'(1);
        // Capture on the final step so result is already registered in DONE.
        // A zero divisor leaves |opa| as the remainder; the sign fix restores opa.
        if (cnt_q == CW'(1)) begin
          state_d = DIV_DONE;
          res_d   = {cond_neg(rem_it, rsign_q),
                     dz_q ? {WIDTH{1'b1}} : cond_neg(quo_it, qsign_q)};
        end
      end
      DIV_DONE: begin
        rdy     = 1'b1;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase

    if (bus.annul) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
      rdy     = 1'b0;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      dz_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      dz_q    <= dz_d;
      res_q   <= res_d;
    end
  end

  assign bus.stall_div = stall;
  assign bus.ready     = rdy;
  assign bus.result    = res_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: latency, stall window, signed fix-up, divide by zero,
// annul, back-to-back and asynchronous reset.
module tb_div_iter;
  import div_iter_pkg::*;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  div_iter_if #(.WIDTH(32)) dif();

  div_iter #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (dif)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Entered at posedge+1; returns in the DONE cycle (posedge+2) or after 40 cycles.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                        input bit hold, output logic [63:0] res, output int lat,
                        output int stalls);
    dif.start      = 1'b1;
    dif.signed_div = sg;
    dif.opa        = a;
    dif.opb        = b;
    res    = 'x;
    lat    = -1;
    stalls = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (dif.stall_div === 1'b1) stalls++;
      if (dif.ready === 1'b1) begin
        lat = cyc;
        res = dif.result;
        if (!hold) dif.start = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) dif.start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (dif.stall_div !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", dif.stall_div); end
    total++; if (dif.ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", dif.ready); end
    total++; if (dif.result !== 64'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", dif.result); end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_divu_basic();
    logic [63:0] res; int lat, st;
    run_op(32'd100, 32'd7, 1'b0, 1'b0, res, lat, st);
    total++; if (lat !== 33) begin bad++; $display("FAIL divu_latency got=%0d exp=33", lat); end
    total++; if (st !== 33) begin bad++; $display("FAIL divu_stall_cycles got=%0d exp=33", st); end
    total++; if (res !== {32'd2, 32'd14}) begin bad++; $display("FAIL divu_100_7 got=%h exp=%h", res, {32'd2, 32'd14}); end
    @(posedge clk); #2;
    total++; if (dif.ready !== 1'b0) begin bad++; $display("FAIL ready_pulse got=%b exp=0", dif.ready); end
    total++; if (dif.result !== {32'd2, 32'd14}) begin bad++; $display("FAIL result_hold got=%h exp=%h", dif.result, {32'd2, 32'd14}); end
    @(posedge clk); #1;
  endtask

  task automatic test_signed();
    logic [31:0] va [6] = '{32'hFFFFFFF9, 32'd7,       32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF8};
    logic [31:0] vb [6] = '{32'd2,       32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1,        32'd2,        32'hFFFFFFFD};
    logic        vs [6] = '{1'b1,        1'b1,         1'b1,         1'b0,         1'b0,         1'b1};
    logic [63:0] ve [6] = '{{32'hFFFFFFFF, 32'hFFFFFFFD}, {32'd1, 32'hFFFFFFFD},
                            {32'd0, 32'h80000000},        {32'd0, 32'hFFFFFFFF},
                            {32'd1, 32'h7FFFFFFC},        {32'hFFFFFFFE, 32'd2}};
    logic [63:0] res; int lat, st;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], vs[i], 1'b0, res, lat, st);
      total++; if (lat !== 33) begin bad++; $display("FAIL signed_latency[%0d] got=%0d exp=33", i, lat); end
      total++; if (res !== ve[i]) begin bad++; $display("FAIL signed_result[%0d] got=%h exp=%h", i, res, ve[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_zero();
    logic [63:0] res; int lat, st;
    run_op(32'd5, 32'd0, 1'b0, 1'b0, res, lat, st);
    total++; if (lat !== 33) begin bad++; $display("FAIL divzero_latency got=%0d exp=33", lat); end
    total++; if (res !== {32'd5, 32'hFFFFFFFF}) begin bad++; $display("FAIL divzero_unsigned got=%h exp=%h", res, {32'd5, 32'hFFFFFFFF}); end
    total++; if ($isunknown({dif.result, dif.ready, dif.stall_div}) !== 1'b0) begin bad++; $display("FAIL divzero_no_x got=%b exp=0", $isunknown({dif.result, dif.ready, dif.stall_div})); end
    @(posedge clk); #1;
    run_op(32'hFFFFFFFB, 32'd0, 1'b1, 1'b0, res, lat, st);
    total++; if (res !== {32'hFFFFFFFB, 32'hFFFFFFFF}) begin bad++; $display("FAIL divzero_signed got=%h exp=%h", res, {32'hFFFFFFFB, 32'hFFFFFFFF}); end
    @(posedge clk); #1;
  endtask

  task automatic test_annul();
    logic [63:0] res; int lat, st, rdy_cnt;
    // Last completed result is -5/0 from the previous scenario.
    dif.start = 1'b1; dif.signed_div = 1'b0; dif.opa = 32'd100; dif.opb = 32'd7;
    for (int c = 0; c < 10; c++) begin @(posedge clk); #1; end
    dif.annul = 1'b1; dif.start = 1'b0;
    #1;
    total++; if (dif.stall_div !== 1'b0) begin bad++; $display("FAIL annul_stall got=%b exp=0", dif.stall_div); end
    @(posedge clk); #1;
    dif.annul = 1'b0;
    #1;
    total++; if (dif.stall_div !== 1'b0) begin bad++; $display("FAIL annul_idle_stall got=%b exp=0", dif.stall_div); end
    rdy_cnt = 0;
    for (int c = 0; c < 40; c++) begin @(posedge clk); #2; if (dif.ready === 1'b1) rdy_cnt++; end
    total++; if (rdy_cnt !== 0) begin bad++; $display("FAIL annul_no_ready got=%0d exp=0", rdy_cnt); end
    total++; if (dif.result !== {32'hFFFFFFFB, 32'hFFFFFFFF}) begin bad++; $display("FAIL annul_result_kept got=%h exp=%h", dif.result, {32'hFFFFFFFB, 32'hFFFFFFFF}); end
    @(posedge clk); #1;
    run_op(32'd9, 32'd3, 1'b0, 1'b0, res, lat, st);
    total++; if (lat !== 33) begin bad++; $display("FAIL after_annul_latency got=%0d exp=33", lat); end
    total++; if (res !== {32'd0, 32'd3}) begin bad++; $display("FAIL after_annul_9_3 got=%h exp=%h", res, {32'd0, 32'd3}); end
    dif.annul = 1'b1;
    #1;
    total++; if (dif.ready !== 1'b0) begin bad++; $display("FAIL annul_done_ready got=%b exp=0", dif.ready); end
    @(posedge clk); #1;
    dif.annul = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [63:0] res; int lat, st;
    run_op(32'd100, 32'd7, 1'b0, 1'b1, res, lat, st);
    total++; if (res !== {32'd2, 32'd14}) begin bad++; $display("FAIL b2b_first got=%h exp=%h", res, {32'd2, 32'd14}); end
    dif.opa = 32'd20; dif.opb = 32'd6;
    #1;
    total++; if (dif.stall_div !== 1'b0) begin bad++; $display("FAIL b2b_done_stall got=%b exp=0", dif.stall_div); end
    @(posedge clk); #1;
    run_op(32'd20, 32'd6, 1'b0, 1'b0, res, lat, st);
    total++; if (lat !== 33) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=33", lat); end
    total++; if (res !== {32'd2, 32'd3}) begin bad++; $display("FAIL b2b_20_6 got=%h exp=%h", res, {32'd2, 32'd3}); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int rdy_cnt;
    dif.start = 1'b1; dif.signed_div = 1'b0; dif.opa = 32'd100; dif.opb = 32'd7;
    for (int c = 0; c < 6; c++) begin @(posedge clk); #1; end
    total++; if (dif.stall_div !== 1'b1) begin bad++; $display("FAIL midreset_busy_stall got=%b exp=1", dif.stall_div); end
    dif.start = 1'b0;
    #1;
    resetn = 1'b0;
    #1;
    total++; if (dif.stall_div !== 1'b0) begin bad++; $display("FAIL midreset_stall got=%b exp=0", dif.stall_div); end
    total++; if (dif.ready !== 1'b0) begin bad++; $display("FAIL midreset_ready got=%b exp=0", dif.ready); end
    total++; if (dif.result !== 64'd0) begin bad++; $display("FAIL midreset_result got=%h exp=0", dif.result); end
    @(posedge clk); #1;
    resetn = 1'b1;
    rdy_cnt = 0;
    for (int c = 0; c < 40; c++) begin @(posedge clk); #2; if (dif.ready === 1'b1) rdy_cnt++; end
    total++; if (rdy_cnt !== 0) begin bad++; $display("FAIL midreset_no_ready got=%0d exp=0", rdy_cnt); end
  endtask

  initial begin
    dif.start      = 1'b0;
    dif.signed_div = 1'b0;
    dif.annul      = 1'b0;
    dif.opa        = '0;
    dif.opb        = '0;
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_zero();
    test_annul();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
